// File: rtl/smem_arbiter.sv
// Round-robin arbiter serialising per-core load/store requests onto one shared-memory port.
// Optional ack watchdog enabled by defining SMEM_ARB_TIMEOUT_EN.
module smem_arbiter #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CORES-1:0]          req_ld,
  input  logic [N_CORES-1:0]          req_st,
  input  logic [N_CORES*ADDR_W-1:0]   req_addr,
  input  logic [N_CORES*DATA_W-1:0]   req_wdata,
  output logic [N_CORES-1:0]          val_data,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ack,
  output logic [$clog2(N_CORES)-1:0]  grant_id,
  output logic                        busy,
  output logic                        err
);

  localparam int IDX_W = $clog2(N_CORES);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state, next_state;

  logic [N_CORES-1:0] req_any;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_d, sel_idx, rr_next;
  logic [IDX_W:0]     scan;
  logic               timed_out;

  logic [N_CORES-1:0] val_data_d;
  logic [DATA_W-1:0]  rdata_d, mem_wdata_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [IDX_W-1:0]   grant_id_d;
  logic               mem_req_d, mem_we_d, busy_d, err_d;

  assign req_any = req_ld | req_st;
  assign rr_next = (grant_id == IDX_W'(N_CORES - 1)) ? '0 : grant_id + 1'b1;

`ifdef SMEM_ARB_TIMEOUT_EN
  logic [$clog2(TIMEOUT+1)-1:0] tmo_cnt;

  // Counts whole ISSUE cycles without an ack; held at zero outside ISSUE so entry always starts clean.
  always_ff @(posedge clk) begin
    if (reset || state != ISSUE)
      tmo_cnt <= '0;
    else if (!timed_out)
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timed_out = (tmo_cnt == ($clog2(TIMEOUT+1))'(TIMEOUT));
`else
  // Without the watchdog ISSUE never times out.
  assign timed_out = (TIMEOUT < 0);
`endif

  // First requesting core at or after rr_ptr, wrapping modulo N_CORES.
  always_comb begin
    sel_idx = '0;
    scan    = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      scan = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (scan >= (IDX_W+1)'(N_CORES))
        scan = scan - (IDX_W+1)'(N_CORES);
      if (req_any[scan[IDX_W-1:0]])
        sel_idx = scan[IDX_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      val_data  <= '0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= next_state;
      rr_ptr    <= rr_ptr_d;
      val_data  <= val_data_d;
      rdata     <= rdata_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      grant_id  <= grant_id_d;
      busy      <= busy_d;
      err       <= err_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|req_any) next_state = ISSUE;
      ISSUE:   if (mem_ack || timed_out) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d    = rr_ptr;
    val_data_d  = val_data;
    rdata_d     = rdata;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    grant_id_d  = grant_id;
    busy_d      = busy;
    err_d       = err;
    case (state)
      IDLE: begin
        if (|req_any) begin
          grant_id_d  = sel_idx;
          mem_addr_d  = req_addr[sel_idx*ADDR_W +: ADDR_W];
          mem_wdata_d = req_wdata[sel_idx*DATA_W +: DATA_W];
          mem_we_d    = req_st[sel_idx] & ~req_ld[sel_idx];
          mem_req_d   = 1'b1;
          busy_d      = 1'b1;
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          mem_req_d            = 1'b0;
          val_data_d           = '0;
          val_data_d[grant_id] = 1'b1;
          if (!mem_we)
            rdata_d = mem_rdata;
        end else if (timed_out) begin
          mem_req_d            = 1'b0;
          val_data_d           = '0;
          val_data_d[grant_id] = 1'b1;
          rdata_d              = '1;
          err_d                = 1'b1;
        end
      end
      RESP: begin
        val_data_d = '0;
        rr_ptr_d   = rr_next;
        busy_d     = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_smem_arbiter.sv
// Directed self-checking bench for smem_arbiter (N_CORES=4, TIMEOUT=8).
module tb_smem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_ld, req_st;
  logic [47:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  val_data;
  logic [7:0]  rdata;
  logic        mem_req, mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [1:0]  grant_id;
  logic        busy, err;

  int checks   = 0;
  int failures = 0;
  int pulses [4];

  smem_arbiter #(.N_CORES(4), .ADDR_W(12), .DATA_W(8), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .req_ld(req_ld), .req_st(req_st),
    .req_addr(req_addr), .req_wdata(req_wdata), .val_data(val_data),
    .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .grant_id(grant_id), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Counts completion pulses per core, sampled just after each edge.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 4; k++)
      if (val_data[k]) pulses[k]++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_ld = '0; req_st = '0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({val_data, rdata, mem_req, mem_we, mem_addr, mem_wdata, grant_id, busy, err} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: val_data=%b rdata=%h mem_req=%b mem_we=%b mem_addr=%h mem_wdata=%h grant_id=%0d busy=%b err=%b, required all zero",
               val_data, rdata, mem_req, mem_we, mem_addr, mem_wdata, grant_id, busy, err);
    end
  endtask

  task automatic test_load();
    req_ld = 4'b0100;
    req_addr[2*12 +: 12] = 12'h3A5;
    tick();
    checks++;
    if ({mem_req, mem_we, mem_addr, grant_id, busy} !== {1'b1, 1'b0, 12'h3A5, 2'd2, 1'b1}) begin
      failures++;
      $display("[TB] FAIL load_issue: mem_req=%b mem_we=%b mem_addr=%h grant_id=%0d busy=%b, required 1 0 3a5 2 1",
               mem_req, mem_we, mem_addr, grant_id, busy);
    end
    mem_ack = 1'b1; mem_rdata = 8'h5C;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({val_data, rdata, mem_req} !== {4'b0100, 8'h5C, 1'b0}) begin
      failures++;
      $display("[TB] FAIL load_resp: val_data=%b rdata=%h mem_req=%b, required 0100 5c 0", val_data, rdata, mem_req);
    end
    req_ld = '0;
    tick();
    checks++;
    if ({val_data, busy} !== {4'b0000, 1'b0}) begin
      failures++;
      $display("[TB] FAIL load_idle: val_data=%b busy=%b, required 0000 0", val_data, busy);
    end
  endtask

  task automatic test_store_wait();
    req_st = 4'b0010;
    req_addr[1*12 +: 12] = 12'h010;
    req_wdata[1*8 +: 8]  = 8'h77;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, grant_id, val_data} !== {1'b1, 1'b1, 12'h010, 8'h77, 2'd1, 4'b0000}) begin
        failures++;
        $display("[TB] FAIL store_hold[%0d]: mem_req=%b mem_we=%b mem_addr=%h mem_wdata=%h grant_id=%0d val_data=%b, required 1 1 010 77 1 0000",
                 i, mem_req, mem_we, mem_addr, mem_wdata, grant_id, val_data);
      end
      if (i < 4) tick();
    end
    mem_ack = 1'b1; mem_rdata = 8'hAA;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({val_data, rdata, mem_req} !== {4'b0010, 8'h5C, 1'b0}) begin
      failures++;
      $display("[TB] FAIL store_resp: val_data=%b rdata=%h mem_req=%b, required 0010 5c 0", val_data, rdata, mem_req);
    end
    req_st = '0;
    tick();
    checks++;
    if ({val_data, busy, rdata} !== {4'b0000, 1'b0, 8'h5C}) begin
      failures++;
      $display("[TB] FAIL store_done: val_data=%b busy=%b rdata=%h, required 0000 0 5c", val_data, busy, rdata);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_addr[k*12 +: 12] = 12'h100 + 12'(k);
      pulses[k] = 0;
    end
    req_ld = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      int g = order[t];
      int waited = 0;
      while (!mem_req && waited < 10) begin
        tick();
        waited++;
      end
      checks++;
      if ({mem_req, grant_id, mem_addr} !== {1'b1, 2'(g), 12'h100 + 12'(g)}) begin
        failures++;
        $display("[TB] FAIL rr_grant[%0d]: mem_req=%b grant_id=%0d mem_addr=%h, required 1 %0d %h",
                 t, mem_req, grant_id, mem_addr, g, 12'h100 + 12'(g));
      end
      mem_ack = 1'b1; mem_rdata = 8'h10 + 8'(t);
      tick();
      mem_ack = 1'b0;
      checks++;
      if ({val_data, rdata} !== {4'(1 << g), 8'h10 + 8'(t)}) begin
        failures++;
        $display("[TB] FAIL rr_resp[%0d]: val_data=%b rdata=%h, required %b %h", t, val_data, rdata, 4'(1 << g), 8'h10 + 8'(t));
      end
      req_ld[g] = 1'b0;
      tick();
      if (t == 0) req_ld[0] = 1'b1;
    end
    tick();
    checks++;
    if (pulses[0] !== 2 || pulses[1] !== 1 || pulses[2] !== 1 || pulses[3] !== 1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rr_pulses: core0=%0d core1=%0d core2=%0d core3=%0d busy=%b, required 2 1 1 1 0",
               pulses[0], pulses[1], pulses[2], pulses[3], busy);
    end
  endtask

  task automatic test_ld_st_conflict();
    req_ld = 4'b1000; req_st = 4'b1000;
    req_addr[3*12 +: 12] = 12'hABC;
    req_wdata[3*8 +: 8]  = 8'h11;
    tick();
    checks++;
    if ({mem_req, mem_we, grant_id, mem_addr} !== {1'b1, 1'b0, 2'd3, 12'hABC}) begin
      failures++;
      $display("[TB] FAIL conflict_issue: mem_req=%b mem_we=%b grant_id=%0d mem_addr=%h, required 1 0 3 abc",
               mem_req, mem_we, grant_id, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 8'h3C;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({val_data, rdata} !== {4'b1000, 8'h3C}) begin
      failures++;
      $display("[TB] FAIL conflict_resp: val_data=%b rdata=%h, required 1000 3c", val_data, rdata);
    end
    req_ld = '0; req_st = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    req_ld = 4'b0010;
    req_addr[1*12 +: 12] = 12'h222;
    tick();
    checks++;
    if ({mem_req, grant_id} !== {1'b1, 2'd1}) begin
      failures++;
      $display("[TB] FAIL midreset_issue: mem_req=%b grant_id=%0d, required 1 1", mem_req, grant_id);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({mem_req, busy, val_data, grant_id} !== {1'b0, 1'b0, 4'b0000, 2'd0}) begin
      failures++;
      $display("[TB] FAIL midreset_clear: mem_req=%b busy=%b val_data=%b grant_id=%0d, required 0 0 0000 0",
               mem_req, busy, val_data, grant_id);
    end
    tick();
    checks++;
    if ({mem_req, grant_id, mem_addr} !== {1'b1, 2'd1, 12'h222}) begin
      failures++;
      $display("[TB] FAIL midreset_reissue: mem_req=%b grant_id=%0d mem_addr=%h, required 1 1 222", mem_req, grant_id, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 8'h99;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({val_data, rdata} !== {4'b0010, 8'h99}) begin
      failures++;
      $display("[TB] FAIL midreset_resp: val_data=%b rdata=%h, required 0010 99", val_data, rdata);
    end
    req_ld = '0;
    tick();
  endtask

  task automatic test_timeout();
    req_ld = 4'b0001;
    req_addr[0 +: 12] = 12'h0F0;
    tick();
`ifdef SMEM_ARB_TIMEOUT_EN
    for (int i = 1; i < 9; i++) begin
      tick();
      checks++;
      if ({mem_req, val_data, err} !== {1'b1, 4'b0000, 1'b0}) begin
        failures++;
        $display("[TB] FAIL timeout_wait[%0d]: mem_req=%b val_data=%b err=%b, required 1 0000 0", i, mem_req, val_data, err);
      end
    end
    tick();
    checks++;
    if ({val_data, rdata, err, mem_req} !== {4'b0001, 8'hFF, 1'b1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL timeout_fire: val_data=%b rdata=%h err=%b mem_req=%b, required 0001 ff 1 0", val_data, rdata, err, mem_req);
    end
    req_ld = '0;
    tick(); tick();
    checks++;
    if ({err, busy, val_data} !== {1'b1, 1'b0, 4'b0000}) begin
      failures++;
      $display("[TB] FAIL timeout_sticky: err=%b busy=%b val_data=%b, required 1 0 0000", err, busy, val_data);
    end
`else
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if ({mem_req, val_data, err, busy} !== {1'b1, 4'b0000, 1'b0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL no_watchdog_wait: mem_req=%b val_data=%b err=%b busy=%b, required 1 0000 0 1", mem_req, val_data, err, busy);
    end
    mem_ack = 1'b1; mem_rdata = 8'h42;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({val_data, rdata, err} !== {4'b0001, 8'h42, 1'b0}) begin
      failures++;
      $display("[TB] FAIL no_watchdog_resp: val_data=%b rdata=%h err=%b, required 0001 42 0", val_data, rdata, err);
    end
    req_ld = '0;
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_wait();
    test_round_robin();
    test_ld_st_conflict();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] bench did not finish");
  end

endmodule
